// File: rtl/trap_unit_v2_pkg.sv
// Shared definitions for the trap controller: FSM state and trap-kind
// encodings, mstatus bit positions and the mtvec vectored-mode value.
package trap_unit_v2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STALL  = 2'd1,
    ST_COMMIT = 2'd2
  } trap_state_e;

  typedef enum logic [1:0] {
    KIND_EXC  = 2'd0,
    KIND_INT  = 2'd1,
    KIND_MRET = 2'd2
  } trap_kind_e;

  localparam int         MSTATUS_MIE_BIT     = 3;
  localparam int         MSTATUS_MPIE_BIT    = 7;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  // Position of the interrupt flag inside mcause for a given datapath width.
  function automatic int mcause_int_bit(input int xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/trap_unit_v2_prio_enc.sv
// trap_prio_enc: lowest-index-wins priority encoder.
//   i_req  in  N    request vector
//   o_id   out IDW  index of the lowest set request (0 when none)
//   o_any  out 1    at least one request is set
module trap_prio_enc #(
  parameter int N   = 16,
  parameter int IDW = 4
) (
  input  logic [N-1:0]   i_req,
  output logic [IDW-1:0] o_id,
  output logic           o_any
);

  // Scan from the top down so the lowest set index is the last to be written.
  always_comb begin
    o_id  = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_id  = IDW'(k);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_unit_v2.sv
// trap_unit_v2: trap controller between decode/execute and the CSR file.
// Arbitrates interrupts, exceptions and mret, stalls the pipeline, picks the
// victim pc, produces the new mcause/mepc/mstatus and redirects fetch.
//   i_clk/i_rstn                 clock, asynchronous active-low reset
//   i_irq                        level interrupt lines
//   i_exc_vld/_code/_pc          exception request from exu
//   i_mret_vld                   mret reached exu
//   i_csr_*                      current mstatus, mtvec, mie, mepc
//   i_bpu_*/i_exu_*              decode / execute stage valid + pc
//   o_pipe_stall                 pipeline freeze while a trap is serviced
//   o_csr_mip                    pending interrupts (combinational)
//   o_trap_update                one-cycle CSR write strobe
//   o_csr_mcause/mepc/mstatus    CSR write values
//   o_trap_repl/_pc              one-cycle jump replacement + target
module trap_unit_v2 #(
  parameter int XLEN = 32,
  parameter int NIRQ = 16,
  parameter int ECW  = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [NIRQ-1:0] i_irq,
  input  logic            i_exc_vld,
  input  logic [ECW-1:0]  i_exc_code,
  input  logic [XLEN-1:0] i_exc_pc,
  input  logic            i_mret_vld,
  input  logic [XLEN-1:0] i_csr_mstatus,
  input  logic [XLEN-1:0] i_csr_mtvec,
  input  logic [XLEN-1:0] i_csr_mie,
  input  logic [XLEN-1:0] i_csr_mepc,
  input  logic            i_bpu_inst_vld,
  input  logic [XLEN-1:0] i_bpu_iaddr,
  input  logic            i_exu_inst_vld,
  input  logic [XLEN-1:0] i_exu_iaddr,
  output logic            o_pipe_stall,
  output logic [XLEN-1:0] o_csr_mip,
  output logic            o_trap_update,
  output logic [XLEN-1:0] o_csr_mcause,
  output logic [XLEN-1:0] o_csr_mepc,
  output logic [XLEN-1:0] o_csr_mstatus,
  output logic            o_trap_repl,
  output logic [XLEN-1:0] o_trap_repl_pc
);
  import trap_unit_v2_pkg::*;

  localparam int IDW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  logic [NIRQ-1:0] w_pending;
  logic [IDW-1:0]  w_irq_id;
  logic            w_irq_any, w_irq_req, w_any_req;
  trap_state_e     r_state, w_state_next;
  trap_kind_e      r_kind, w_kind_next;
  logic [ECW-1:0]  r_code;
  logic [IDW-1:0]  r_id;
  logic [XLEN-1:0] r_exc_pc;
  logic            w_victim_ok, w_commit;
  logic [XLEN-1:0] w_victim_pc, w_base, w_target, w_mcause_new, w_mstatus_new;
  logic            r_stall, r_update, r_repl;
  logic [XLEN-1:0] r_mcause, r_mepc, r_mstatus, r_repl_pc;
  logic            w_unused_ok;

  assign w_pending = i_irq & i_csr_mie[NIRQ-1:0];
  assign o_csr_mip = {{(XLEN-NIRQ){1'b0}}, w_pending};

  trap_prio_enc #(.N(NIRQ), .IDW(IDW)) u_prio (
    .i_req (w_pending),
    .o_id  (w_irq_id),
    .o_any (w_irq_any)
  );

  assign w_irq_req = i_csr_mstatus[MSTATUS_MIE_BIT] & w_irq_any;
  assign w_any_req = i_exc_vld | i_mret_vld | w_irq_req;

  // Exception beats mret beats interrupt.
  always_comb begin
    w_kind_next = KIND_INT;
    if (i_exc_vld)       w_kind_next = KIND_EXC;
    else if (i_mret_vld) w_kind_next = KIND_MRET;
  end

  // An interrupt needs a live instruction to resume at; the older stage wins.
  always_comb begin
    w_victim_ok = 1'b0;
    w_victim_pc = r_exc_pc;
    case (r_kind)
      KIND_EXC, KIND_MRET: w_victim_ok = 1'b1;
      default: begin
        if (i_exu_inst_vld) begin
          w_victim_ok = 1'b1;
          w_victim_pc = i_exu_iaddr;
        end else if (i_bpu_inst_vld) begin
          w_victim_ok = 1'b1;
          w_victim_pc = i_bpu_iaddr;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_req) w_state_next = ST_STALL;
      ST_STALL:  if (w_victim_ok) w_state_next = ST_COMMIT;
      ST_COMMIT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: values loaded into the output registers on commit.
  always_comb begin
    w_commit      = (r_state == ST_STALL) && w_victim_ok;
    w_base        = {i_csr_mtvec[XLEN-1:2], 2'b00};
    w_target      = w_base;
    w_mcause_new  = '0;
    w_mstatus_new = i_csr_mstatus;
    if (r_kind == KIND_MRET) begin
      w_mstatus_new[MSTATUS_MIE_BIT]  = i_csr_mstatus[MSTATUS_MPIE_BIT];
      w_mstatus_new[MSTATUS_MPIE_BIT] = 1'b1;
      w_target = {i_csr_mepc[XLEN-1:2], 2'b00};
    end else begin
      w_mstatus_new[MSTATUS_MPIE_BIT] = i_csr_mstatus[MSTATUS_MIE_BIT];
      w_mstatus_new[MSTATUS_MIE_BIT]  = 1'b0;
      if (r_kind == KIND_INT) begin
        w_mcause_new[mcause_int_bit(XLEN)] = 1'b1;
        w_mcause_new[IDW-1:0]              = r_id;
        if (i_csr_mtvec[1:0] == MTVEC_MODE_VECTORED)
          w_target = w_base + (XLEN'(r_id) << 2);
      end else begin
        w_mcause_new[ECW-1:0] = r_code;
      end
    end
  end

  // Request capture; an interrupt id is frozen here and never re-evaluated.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_kind   <= KIND_EXC;
      r_code   <= '0;
      r_id     <= '0;
      r_exc_pc <= '0;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_kind   <= w_kind_next;
      r_code   <= i_exc_code;
      r_id     <= w_irq_id;
      r_exc_pc <= i_exc_pc;
    end
  end

  // Output registers; CSR values hold between commits.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_stall   <= 1'b0;
      r_update  <= 1'b0;
      r_repl    <= 1'b0;
      r_mcause  <= '0;
      r_mepc    <= '0;
      r_mstatus <= '0;
      r_repl_pc <= '0;
    end else begin
      r_stall  <= (w_state_next != ST_IDLE);
      r_update <= w_commit;
      r_repl   <= w_commit;
      if (w_commit) begin
        r_repl_pc <= w_target;
        r_mstatus <= w_mstatus_new;
        if (r_kind != KIND_MRET) begin
          r_mcause <= w_mcause_new;
          r_mepc   <= {w_victim_pc[XLEN-1:2], 2'b00};
        end
      end
    end
  end

  assign o_pipe_stall   = r_stall;
  assign o_trap_update  = r_update;
  assign o_trap_repl    = r_repl;
  assign o_csr_mcause   = r_mcause;
  assign o_csr_mepc     = r_mepc;
  assign o_csr_mstatus  = r_mstatus;
  assign o_trap_repl_pc = r_repl_pc;

  // Bits that are architecturally ignored here.
  assign w_unused_ok = ^{i_csr_mie[XLEN-1:NIRQ], i_csr_mepc[1:0], w_victim_pc[1:0]};

endmodule

// File: tb/tb_trap_unit_v2.sv
module tb_trap_unit_v2;
  localparam int K_EXC = 0, K_INT = 1, K_MRET = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] irq;
  logic        exc_vld, mret_vld, bpu_vld, exu_vld;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc, csr_mstatus, csr_mtvec, csr_mie, csr_mepc, bpu_iaddr, exu_iaddr;
  logic        o_pipe_stall, o_trap_update, o_trap_repl;
  logic [31:0] o_csr_mip, o_csr_mcause, o_csr_mepc, o_csr_mstatus, o_trap_repl_pc;

  initial forever #5 clk = ~clk;

  trap_unit_v2 #(.XLEN(32), .NIRQ(16), .ECW(4)) dut (
    .i_clk(clk), .i_rstn(rst_n), .i_irq(irq),
    .i_exc_vld(exc_vld), .i_exc_code(exc_code), .i_exc_pc(exc_pc), .i_mret_vld(mret_vld),
    .i_csr_mstatus(csr_mstatus), .i_csr_mtvec(csr_mtvec), .i_csr_mie(csr_mie), .i_csr_mepc(csr_mepc),
    .i_bpu_inst_vld(bpu_vld), .i_bpu_iaddr(bpu_iaddr), .i_exu_inst_vld(exu_vld), .i_exu_iaddr(exu_iaddr),
    .o_pipe_stall(o_pipe_stall), .o_csr_mip(o_csr_mip), .o_trap_update(o_trap_update),
    .o_csr_mcause(o_csr_mcause), .o_csr_mepc(o_csr_mepc), .o_csr_mstatus(o_csr_mstatus),
    .o_trap_repl(o_trap_repl), .o_trap_repl_pc(o_trap_repl_pc)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A trap in flight is a record (kind, code/id, pc). It waits until a victim
  // pc exists, then produces one commit with the architectural CSR results.
  bit          m_busy = 1'b0, m_commit = 1'b0;
  int          m_kind = 0, m_id = 0;
  logic [3:0]  m_code = '0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_mcause = '0, m_mepc = '0, m_mstatus = '0, m_repl_pc = '0;

  function automatic int lowest(input logic [15:0] p);
    for (int k = 0; k < 16; k++) if (p[k]) return k;
    return 0;
  endfunction

  function automatic logic [31:0] exp_target(input int kind, input int id,
                                             input logic [31:0] mtvec, input logic [31:0] mepc);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
    if (kind == K_MRET) return mepc & 32'hFFFF_FFFC;
    if (kind == K_INT && mtvec[1:0] == 2'd1) return base + 32'(id * 4);
    return base;
  endfunction

  function automatic logic [31:0] exp_mstatus(input int kind, input logic [31:0] ms);
    logic [31:0] m;
    m = ms;
    if (kind == K_MRET) begin m[3] = ms[7]; m[7] = 1'b1; end
    else                begin m[7] = ms[3]; m[3] = 1'b0; end
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_commit <= 1'b0; m_mcause <= '0; m_mepc <= '0;
      m_mstatus <= '0; m_repl_pc <= '0;
    end else if (m_commit) begin
      m_commit <= 1'b0;
      m_busy   <= 1'b0;
    end else if (m_busy) begin
      if (m_kind != K_INT || exu_vld || bpu_vld) begin
        m_commit  <= 1'b1;
        m_repl_pc <= exp_target(m_kind, m_id, csr_mtvec, csr_mepc);
        m_mstatus <= exp_mstatus(m_kind, csr_mstatus);
        if (m_kind != K_MRET) begin
          m_mcause <= (m_kind == K_INT) ? (32'h8000_0000 | 32'(m_id)) : {28'b0, m_code};
          m_mepc   <= ((m_kind == K_EXC) ? m_pc : exu_vld ? exu_iaddr : bpu_iaddr) & 32'hFFFF_FFFC;
        end
      end
    end else begin
      if (exc_vld) begin
        m_busy <= 1'b1; m_kind <= K_EXC; m_code <= exc_code; m_pc <= exc_pc;
      end else if (mret_vld) begin
        m_busy <= 1'b1; m_kind <= K_MRET;
      end else if (csr_mstatus[3] && (irq & csr_mie[15:0]) != 16'h0) begin
        m_busy <= 1'b1; m_kind <= K_INT; m_id <= lowest(irq & csr_mie[15:0]);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("mip", o_csr_mip, {16'h0, irq & csr_mie[15:0]});
    check("stall", 32'(o_pipe_stall), 32'(m_busy));
    check("update", 32'(o_trap_update), 32'(m_commit));
    check("repl", 32'(o_trap_repl), 32'(m_commit));
    check("mcause", o_csr_mcause, m_mcause);
    check("mepc", o_csr_mepc, m_mepc);
    check("mstatus", o_csr_mstatus, m_mstatus);
    check("repl_pc", o_trap_repl_pc, m_repl_pc);
  end

  int upd_cnt = 0;
  always @(negedge clk) if (o_trap_update) upd_cnt++;

  task automatic wait_update(input int limit, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      seen = o_trap_update;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL update_timeout: no o_trap_update within %0d cycles, required one", limit);
    end
  endtask

  task automatic idle_inputs();
    irq = '0; exc_vld = 0; mret_vld = 0; bpu_vld = 0; exu_vld = 0;
    exc_code = '0; exc_pc = '0; bpu_iaddr = '0; exu_iaddr = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int n, u0;
    idle_inputs();
    csr_mstatus = '0; csr_mtvec = '0; csr_mie = '0; csr_mepc = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(o_pipe_stall), 32'h0);
    check("rst_mcause", o_csr_mcause, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: vectored interrupt, id 2
    #1;
    csr_mstatus = 32'h8; csr_mie = 32'hFFFF; irq = 16'h0014;
    exu_vld = 1; exu_iaddr = 32'h100; csr_mtvec = 32'h8000_0001;
    wait_update(10, n);
    check("t1_latency", 32'(n - 1), 32'd2);
    check("t1_mcause", o_csr_mcause, 32'h8000_0002);
    check("t1_mepc", o_csr_mepc, 32'h100);
    check("t1_repl_pc", o_trap_repl_pc, 32'h8000_0008);
    check("t1_mstatus", o_csr_mstatus, 32'h80);
    irq = '0;
    repeat (3) @(posedge clk);

    // 2: masked globally, then masked per line
    #1 csr_mstatus = 32'h0; irq = 16'h0014;
    repeat (4) @(negedge clk);
    check("t2_mip", o_csr_mip, 32'h14);
    check("t2_stall", 32'(o_pipe_stall), 32'h0);
    csr_mstatus = 32'h8; csr_mie = 32'hFFEB;
    repeat (4) @(negedge clk);
    check("t2_mip_masked", o_csr_mip, 32'h0);
    check("t2_stall_masked", 32'(o_pipe_stall), 32'h0);
    irq = '0; csr_mie = 32'hFFFF;
    @(posedge clk);

    // 3: exception wins over irq[0]; irq taken afterwards
    #1 csr_mtvec = 32'h1001; exu_iaddr = 32'h500;
    exc_vld = 1; exc_code = 4'd2; exc_pc = 32'h204; irq = 16'h0001;
    @(posedge clk); #1 exc_vld = 0;
    wait_update(10, n);
    check("t3_mcause", o_csr_mcause, 32'h2);
    check("t3_mepc", o_csr_mepc, 32'h204);
    check("t3_repl_pc", o_trap_repl_pc, 32'h1000);
    wait_update(10, n);
    check("t3_irq_mcause", o_csr_mcause, 32'h8000_0000);
    check("t3_irq_mepc", o_csr_mepc, 32'h500);
    irq = '0;
    repeat (3) @(posedge clk);

    // 4: no valid stage for 5 cycles
    #1 exu_vld = 0; bpu_vld = 0; csr_mtvec = 32'h2000; irq = 16'h0008;
    u0 = upd_cnt;
    @(negedge clk);
    check("t4_stall_pre", 32'(o_pipe_stall), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall_held", 32'(o_pipe_stall), 32'h1);
    end
    bpu_vld = 1; bpu_iaddr = 32'h40;
    wait_update(3, n);
    check("t4_latency", 32'(n), 32'd1);
    check("t4_mepc", o_csr_mepc, 32'h40);
    check("t4_mcause", o_csr_mcause, 32'h8000_0003);
    check("t4_repl_pc", o_trap_repl_pc, 32'h2000);
    irq = '0; bpu_vld = 0;
    repeat (4) @(negedge clk);
    #1 check("t4_single_pulse", 32'(upd_cnt - u0), 32'd1);
    @(posedge clk);

    // 5: mret
    #1 csr_mstatus = 32'h80; csr_mepc = 32'h302; mret_vld = 1;
    @(posedge clk); #1 mret_vld = 0;
    wait_update(10, n);
    check("t5_latency", 32'(n), 32'd2);
    check("t5_mstatus", o_csr_mstatus, 32'h88);
    check("t5_repl_pc", o_trap_repl_pc, 32'h300);
    check("t5_mcause_kept", o_csr_mcause, 32'h8000_0003);
    check("t5_mepc_kept", o_csr_mepc, 32'h40);
    repeat (3) @(posedge clk);

    // 6: reset during STALL
    #1 csr_mstatus = 32'h8; irq = 16'h0008;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_stall", 32'(o_pipe_stall), 32'h0);
    check("t6_mcause", o_csr_mcause, 32'h0);
    check("t6_mepc", o_csr_mepc, 32'h0);
    check("t6_repl_pc", o_trap_repl_pc, 32'h0);
    irq = '0;
    u0 = upd_cnt;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1 check("t6_no_strobe", 32'(upd_cnt - u0), 32'd0);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 7) == 0) irq = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 63) == 0) csr_mie = $urandom;
      csr_mstatus = ($urandom & 32'hFFFF_FF77) | ($urandom_range(0, 3) != 0 ? 32'h8 : 32'h0)
                    | ($urandom_range(0, 1) != 0 ? 32'h80 : 32'h0);
      if ($urandom_range(0, 31) == 0) csr_mtvec = $urandom;
      csr_mepc = $urandom;
      exc_vld = ($urandom_range(0, 15) == 0);
      exc_code = 4'($urandom);
      exc_pc = $urandom;
      mret_vld = ($urandom_range(0, 23) == 0);
      exu_vld = ($urandom_range(0, 2) == 0);
      bpu_vld = ($urandom_range(0, 2) == 0);
      exu_iaddr = $urandom;
      bpu_iaddr = $urandom;
    end
    @(posedge clk); #1 idle_inputs();
    repeat (8) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
